sequencer: RTL

Major-state and phase sequencer for the PDP-8 core. Runs each instruction through FETCH, an optional DEFER (indirect/auto-index) stage and EXECUTE. During EXECUTE it generates the ck1..ck6 / stb1..stb6 phase strobes consumed by the instruction decoders, and it returns to FETCH when they raise `done`. It also owns run/halt control, the interrupt entry (`irqOverride`) and an execute-timeout error.

---
 rtl/sequencer_if.sv | 31 +++
 rtl/sequencer.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/sequencer_if.sv
// PDP-8 sequencer bundle: run/decode/interrupt controls in, fetch/defer/execute strobes out.
// The master modport is the sequencer itself; slave is the datapath/decoder side.
interface sequencer_if;
  // Handshake: the decoders hold `done` high in an EXEC cycle to end the instruction;
  // the sequencer samples it only in EXEC, and F0 of the next instruction follows one cycle later.
  logic run, haltReq, done;
  logic instIsMRI, instIsIND, instIsPPIND;
  logic irqReq, irqEnabled;
  logic pc2rama, ram_oe, ir_ck, pc_ck;
  logic ir2rama, ind_ck, ind_inc, ind2ramd, ram_we;
  logic ck1, ck2, ck3, ck4, ck5, ck6;
  logic stb1, stb2, stb3, stb4, stb5, stb6;
  logic irqOverride, irqAck, running, error;
  logic [3:0] dbg_state;
  logic [2:0] dbg_k;
  logic       dbg_h;

  modport master (
    input  run, haltReq, done, instIsMRI, instIsIND, instIsPPIND, irqReq, irqEnabled,
    output pc2rama, ram_oe, ir_ck, pc_ck, ir2rama, ind_ck, ind_inc, ind2ramd, ram_we,
    output ck1, ck2, ck3, ck4, ck5, ck6, stb1, stb2, stb3, stb4, stb5, stb6,
    output irqOverride, irqAck, running, error, dbg_state, dbg_k, dbg_h
  );

  modport slave (
    output run, haltReq, done, instIsMRI, instIsIND, instIsPPIND, irqReq, irqEnabled,
    input  pc2rama, ram_oe, ir_ck, pc_ck, ir2rama, ind_ck, ind_inc, ind2ramd, ram_we,
    input  ck1, ck2, ck3, ck4, ck5, ck6, stb1, stb2, stb3, stb4, stb5, stb6,
    input  irqOverride, irqAck, running, error, dbg_state, dbg_k, dbg_h
  );
endinterface

// File: rtl/sequencer.sv
// PDP-8 major-state / phase sequencer (FETCH, DEFER, EXECUTE, run/halt, interrupt entry).
// Optional single-step control from HALT is enabled by defining SEQ_SINGLESTEP_EN.
module sequencer (
  input  logic clk,
  input  logic reset,
`ifdef SEQ_SINGLESTEP_EN
  input  logic step,
`endif
  sequencer_if.master bus
);

  typedef enum logic [3:0] {
    S_HALT, S_F0, S_F1, S_DEC, S_D0, S_D1, S_D2, S_D3, S_EXEC
  } state_t;

  typedef struct packed {
    logic       pc2rama, ram_oe, ir_ck, pc_ck;
    logic       ir2rama, ind_ck, ind_inc, ind2ramd, ram_we;
    logic [5:0] ck;
    logic [5:0] stb;
    logic       running;
  } outs_t;

  state_t     state, nxt_state;
  logic [2:0] k, nxt_k;
  logic       h, nxt_h;
  logic       ovr, nxt_ovr;
  logic       nxt_ack, ack;
  logic       err, nxt_err;
  logic       step_rise;
  outs_t      outs;

  // Output decode applied to the next state so every strobe comes straight from a flop.
  function automatic outs_t decode(state_t s, logic [2:0] kk, logic hh, logic o_ovr);
    outs_t o;
    o = '0;
    case (s)
      S_F0:   begin o.pc2rama = 1'b1; o.ram_oe = 1'b1; end
      S_F1:   begin
        o.pc2rama = 1'b1; o.ram_oe = 1'b1; o.ir_ck = 1'b1; o.pc_ck = !o_ovr;
      end
      S_D0:   begin o.ir2rama = 1'b1; o.ram_oe = 1'b1; end
      S_D1:   begin o.ir2rama = 1'b1; o.ram_oe = 1'b1; o.ind_ck = 1'b1; end
      S_D2:   o.ind_inc = 1'b1;
      S_D3:   begin o.ir2rama = 1'b1; o.ind2ramd = 1'b1; o.ram_we = 1'b1; end
      S_EXEC: begin
        if (!hh) o.ck  = 6'b000001 << (kk - 3'd1);
        else     o.stb = 6'b000001 << (kk - 3'd1);
      end
      default: o = '0;
    endcase
    o.running = (s != S_HALT);
    return o;
  endfunction

`ifdef SEQ_SINGLESTEP_EN
  logic step_q;
  always_ff @(posedge clk) begin
    if (reset) step_q <= 1'b0;
    else       step_q <= step;
  end
  assign step_rise = step && !step_q && !bus.run;
`else
  assign step_rise = 1'b0;
`endif

  always_comb begin
    nxt_state = state;
    nxt_k     = k;
    nxt_h     = h;
    nxt_ovr   = ovr;
    nxt_ack   = 1'b0;
    nxt_err   = err;
    case (state)
      S_HALT: if (!err && (bus.run || step_rise)) nxt_state = S_F0;
      S_F0:   nxt_state = S_F1;
      S_F1:   nxt_state = S_DEC;
      S_DEC: begin
        if (bus.instIsMRI && (bus.instIsIND || bus.instIsPPIND)) nxt_state = S_D0;
        else begin nxt_state = S_EXEC; nxt_k = 3'd1; nxt_h = 1'b0; end
      end
      S_D0:   nxt_state = S_D1;
      S_D1: begin
        if (bus.instIsPPIND) nxt_state = S_D2;
        else begin nxt_state = S_EXEC; nxt_k = 3'd1; nxt_h = 1'b0; end
      end
      S_D2:   nxt_state = S_D3;
      S_D3:   begin nxt_state = S_EXEC; nxt_k = 3'd1; nxt_h = 1'b0; end
      S_EXEC: begin
        if (bus.done) begin
          nxt_ovr = 1'b0;
          if (bus.haltReq || !bus.run) nxt_state = S_HALT;
          else if (bus.irqReq && bus.irqEnabled && !ovr) begin
            nxt_ack = 1'b1; nxt_ovr = 1'b1; nxt_state = S_F0;
          end else nxt_state = S_F0;
        end else if (k == 3'd6 && h) begin
          // stb6 finished without done: the decoders are stuck, stop the machine.
          nxt_err = 1'b1; nxt_ovr = 1'b0; nxt_state = S_HALT;
        end else begin
          nxt_h = !h;
          if (h) nxt_k = k + 3'd1;
        end
      end
      default: nxt_state = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_HALT;
      k     <= 3'd1;
      h     <= 1'b0;
      ovr   <= 1'b0;
      ack   <= 1'b0;
      err   <= 1'b0;
      outs  <= '0;
    end else begin
      state <= nxt_state;
      k     <= nxt_k;
      h     <= nxt_h;
      ovr   <= nxt_ovr;
      ack   <= nxt_ack;
      err   <= nxt_err;
      outs  <= decode(nxt_state, nxt_k, nxt_h, nxt_ovr);
    end
  end

  assign bus.pc2rama  = outs.pc2rama;
  assign bus.ram_oe   = outs.ram_oe;
  assign bus.ir_ck    = outs.ir_ck;
  assign bus.pc_ck    = outs.pc_ck;
  assign bus.ir2rama  = outs.ir2rama;
  assign bus.ind_ck   = outs.ind_ck;
  assign bus.ind_inc  = outs.ind_inc;
  assign bus.ind2ramd = outs.ind2ramd;
  assign bus.ram_we   = outs.ram_we;
  assign {bus.ck6, bus.ck5, bus.ck4, bus.ck3, bus.ck2, bus.ck1} = outs.ck;
  assign {bus.stb6, bus.stb5, bus.stb4, bus.stb3, bus.stb2, bus.stb1} = outs.stb;
  assign bus.running     = outs.running;
  assign bus.irqOverride = ovr;
  assign bus.irqAck      = ack;
  assign bus.error       = err;
  assign bus.dbg_state   = state;
  assign bus.dbg_k       = k;
  assign bus.dbg_h       = h;

endmodule
